// File: rtl/usb_buf_pkg.sv
// ---------------------------------------------------------------------------
// usb_buf_pkg
// Shared types and helpers for the USB data FIFO.
//   xfer_size_t    : encoding of bus-side access sizes (1, 2 or 4 bytes)
//   size_to_bytes  : number of bytes moved for a given access size
// ---------------------------------------------------------------------------
package usb_buf_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } xfer_size_t;

  // The reserved encoding behaves like a full word access so a stray
  // size value still moves a well-defined number of bytes.
  function automatic logic [2:0] size_to_bytes(input xfer_size_t size);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usb_data_fifo_buffer_ram.sv
// ---------------------------------------------------------------------------
// buffer_ram
// DEPTH x DATA_WIDTH register file backing the USB data FIFO.
// Ports:
//   clk       : write clock (rising edge)
//   wr_en     : write enable for this cycle
//   wr_ptr    : address of write lane 0; lane i writes (wr_ptr+i) mod DEPTH
//   wr_count  : number of lanes written (lanes 0..wr_count-1)
//   wr_data   : write data, lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   rd_ptr    : address of read lane 0; lane i reads (rd_ptr+i) mod DEPTH
//   rd_data   : combinational read data, same lane packing as wr_data
// Storage is deliberately not reset; the FIFO pointers define validity.
// ---------------------------------------------------------------------------
module buffer_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int BUS_BYTES  = 4,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(BUS_BYTES + 1)
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [PTR_W-1:0]                wr_ptr,
  input  logic [CNT_W-1:0]                wr_count,
  input  logic [BUS_BYTES*DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0]                rd_ptr,
  output logic [BUS_BYTES*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Multi-lane write: lanes land on consecutive addresses, and the pointer
  // width makes the address wrap from DEPTH-1 back to 0 naturally.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BUS_BYTES; i++) begin
        if (i < int'(wr_count)) begin
          mem[PTR_W'(wr_ptr + PTR_W'(i))] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // All read lanes are always presented; the FIFO decides which are used.
  always_comb begin
    for (int i = 0; i < BUS_BYTES; i++) begin
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[PTR_W'(rd_ptr + PTR_W'(i))];
    end
  end

endmodule

// File: rtl/usb_data_fifo.sv
// ---------------------------------------------------------------------------
// usb_data_fifo
// Byte FIFO shared by the AHB-lite slave (multi-byte access) and the USB
// TX/RX protocol engines (single-byte access).
// Ports:
//   clk, n_rst            : clock, asynchronous active-low reset
//   clear                 : bus-side empty + clear error flags
//   flush                 : USB-side empty, error flags retained
//   store_tx_data         : bus push of tx_size bytes from tx_data
//   get_rx_data           : bus pop of rx_size bytes into rx_data
//   store_rx_packet_data  : USB push of rx_packet_data
//   get_tx_packet_data    : USB pop into tx_packet_data
//   buffer_occupancy      : entries held; buffer_full / buffer_empty flags
//   overflow_err          : sticky, a push was rejected
//   underflow_err         : sticky, a pop was rejected
// ---------------------------------------------------------------------------
module usb_data_fifo
  import usb_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int BUS_BYTES  = 4,
  localparam int OCC_W     = $clog2(DEPTH + 1),
  localparam int BUS_W     = BUS_BYTES * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  flush,
  input  logic                  store_tx_data,
  input  logic [1:0]            tx_size,
  input  logic [BUS_W-1:0]      tx_data,
  input  logic                  get_rx_data,
  input  logic [1:0]            rx_size,
  output logic [BUS_W-1:0]      rx_data,
  input  logic                  store_rx_packet_data,
  input  logic [DATA_WIDTH-1:0] rx_packet_data,
  input  logic                  get_tx_packet_data,
  output logic [DATA_WIDTH-1:0] tx_packet_data,
  output logic [OCC_W-1:0]      buffer_occupancy,
  output logic                  buffer_full,
  output logic                  buffer_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(BUS_BYTES + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic [OCC_W-1:0] space;
  logic [OCC_W-1:0] push_n;
  logic [OCC_W-1:0] pop_n;
  logic             ctrl_reset;
  logic             push_req;
  logic             pop_req;
  logic             push_ok;
  logic             pop_ok;
  logic             push_lost;
  logic             pop_lost;
  logic             overflow_set;
  logic             underflow_set;
  logic [BUS_W-1:0] wr_data;
  logic [BUS_W-1:0] rd_data;
  logic [BUS_W-1:0] rx_pop_data;

  // Bytes moved by a bus access, never more than the bus has lanes for.
  function automatic logic [OCC_W-1:0] lane_count(input logic [1:0] size);
    logic [2:0] n;
    n = size_to_bytes(xfer_size_t'(size));
    if (int'(n) > BUS_BYTES) n = 3'(BUS_BYTES);
    return OCC_W'(n);
  endfunction

  buffer_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .BUS_BYTES  (BUS_BYTES)
  ) u_ram (
    .clk      (clk),
    .wr_en    (push_ok),
    .wr_ptr   (wr_ptr),
    .wr_count (CNT_W'(push_n)),
    .wr_data  (wr_data),
    .rd_ptr   (rd_ptr),
    .rd_data  (rd_data)
  );

  // Arbitration and acceptance. The USB engine wins the push side, the bus
  // wins the pop side; the loser is dropped and flagged. Every request is
  // judged against the occupancy at the start of the cycle, all-or-nothing.
  // clear/flush suppress all traffic that cycle without raising errors.
  always_comb begin
    ctrl_reset    = clear || flush;
    space         = OCC_W'(DEPTH) - occ;
    push_req      = store_rx_packet_data || store_tx_data;
    pop_req       = get_rx_data || get_tx_packet_data;
    push_lost     = store_rx_packet_data && store_tx_data;
    pop_lost      = get_rx_data && get_tx_packet_data;
    push_n        = store_rx_packet_data ? OCC_W'(1) : lane_count(tx_size);
    pop_n         = get_rx_data ? lane_count(rx_size) : OCC_W'(1);
    push_ok       = !ctrl_reset && push_req && (push_n <= space);
    pop_ok        = !ctrl_reset && pop_req && (pop_n <= occ);
    overflow_set  = !ctrl_reset && (push_lost || (push_req && !push_ok));
    underflow_set = !ctrl_reset && (pop_lost || (pop_req && !pop_ok));
    occ_next      = occ + (push_ok ? push_n : '0) - (pop_ok ? pop_n : '0);
    wr_data       = store_rx_packet_data ? BUS_W'(rx_packet_data) : tx_data;
  end

  // Bus pop data: only the requested lanes are passed, upper lanes read 0.
  always_comb begin
    rx_pop_data = '0;
    for (int i = 0; i < BUS_BYTES; i++) begin
      if (i < int'(pop_n)) begin
        rx_pop_data[i*DATA_WIDTH +: DATA_WIDTH] = rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pointers, occupancy, flags, sticky errors and registered pop outputs.
  // Flags are computed from occ_next so they always agree with occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      buffer_full    <= 1'b0;
      buffer_empty   <= 1'b1;
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
      rx_data        <= '0;
      tx_packet_data <= '0;
    end else if (ctrl_reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      buffer_full  <= 1'b0;
      buffer_empty <= 1'b1;
      if (clear) begin
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(push_n);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(pop_n);
      occ          <= occ_next;
      buffer_full  <= (occ_next == OCC_W'(DEPTH));
      buffer_empty <= (occ_next == '0);
      if (overflow_set)  overflow_err  <= 1'b1;
      if (underflow_set) underflow_err <= 1'b1;
      if (pop_ok && get_rx_data)  rx_data        <= rx_pop_data;
      if (pop_ok && !get_rx_data) tx_packet_data <= rd_data[DATA_WIDTH-1:0];
    end
  end

  assign buffer_occupancy = occ;

endmodule

// File: tb/tb_usb_data_fifo.sv
// ---------------------------------------------------------------------------
// tb_usb_data_fifo
// Directed bench for usb_data_fifo. Each pop request pushes its expected
// output onto a queue; a monitor compares registered pop outputs on the
// falling edge after the request. Status outputs are checked #1 after edges.
// ---------------------------------------------------------------------------
module tb_usb_data_fifo;

  logic        tb_clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic        flush;
  logic        store_tx_data;
  logic [1:0]  tx_size;
  logic [31:0] tx_data;
  logic        get_rx_data;
  logic [1:0]  rx_size;
  logic [31:0] rx_data;
  logic        store_rx_packet_data;
  logic [7:0]  rx_packet_data;
  logic        get_tx_packet_data;
  logic [7:0]  tx_packet_data;
  logic [6:0]  buffer_occupancy;
  logic        buffer_full;
  logic        buffer_empty;
  logic        overflow_err;
  logic        underflow_err;

  typedef struct {
    bit          is_rx;
    logic [31:0] value;
    int          tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   pop_tag     = 0;
  logic mon_rx      = 1'b0;
  logic mon_tx      = 1'b0;

  usb_data_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (64),
    .BUS_BYTES  (4)
  ) dut (
    .clk                  (tb_clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .flush                (flush),
    .store_tx_data        (store_tx_data),
    .tx_size              (tx_size),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_size              (rx_size),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_full          (buffer_full),
    .buffer_empty         (buffer_empty),
    .overflow_err         (overflow_err),
    .underflow_err        (underflow_err)
  );

  always #5 tb_clk = ~tb_clk;

  // Remember which pop outputs the DUT should have updated at this edge.
  always @(posedge tb_clk) begin
    mon_rx <= get_rx_data && n_rst;
    mon_tx <= get_tx_packet_data && n_rst && !get_rx_data;
  end

  // Scoreboard monitor: compare the presented pop output with the queue head.
  always @(negedge tb_clk) begin
    exp_t        e;
    logic [31:0] act;
    if (mon_rx || mon_tx) begin
      vectors++;
      act = mon_rx ? rx_data : {24'h0, tx_packet_data};
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL pop_unexpected: got 0x%08h, required no pop output", act);
      end else begin
        e = exp_q.pop_front();
        if (e.is_rx != mon_rx || act !== e.value) begin
          miscompares++;
          $display("[TB] FAIL pop_%0d %s: got 0x%08h, required 0x%08h",
                   e.tag, e.is_rx ? "rx_data" : "tx_packet_data", act, e.value);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_pop(input bit is_rx, input logic [31:0] value);
    exp_t e;
    e.is_rx = is_rx;
    e.value = value;
    e.tag   = pop_tag;
    pop_tag++;
    exp_q.push_back(e);
  endtask

  // Run one clock with the currently driven strobes, then release them.
  task automatic apply_stimulus();
    @(posedge tb_clk);
    #1;
    store_tx_data        = 1'b0;
    get_rx_data          = 1'b0;
    store_rx_packet_data = 1'b0;
    get_tx_packet_data   = 1'b0;
    clear                = 1'b0;
    flush                = 1'b0;
  endtask

  task automatic usb_push(input logic [7:0] b);
    store_rx_packet_data = 1'b1;
    rx_packet_data       = b;
    apply_stimulus();
  endtask

  task automatic bus_push(input logic [1:0] size, input logic [31:0] data);
    store_tx_data = 1'b1;
    tx_size       = size;
    tx_data       = data;
    apply_stimulus();
  endtask

  task automatic usb_pop(input logic [7:0] req);
    get_tx_packet_data = 1'b1;
    expect_pop(1'b0, {24'h0, req});
    apply_stimulus();
  endtask

  task automatic bus_pop(input logic [1:0] size, input logic [31:0] req);
    get_rx_data = 1'b1;
    rx_size     = size;
    expect_pop(1'b1, req);
    apply_stimulus();
  endtask

  task automatic check_status(input string tag, input int occ, input bit full, input bit empty,
                              input bit ovf, input bit unf);
    check_output({tag, "_occupancy"}, 32'(buffer_occupancy), 32'(occ));
    check_output({tag, "_full"}, 32'(buffer_full), 32'(full));
    check_output({tag, "_empty"}, 32'(buffer_empty), 32'(empty));
    check_output({tag, "_overflow_err"}, 32'(overflow_err), 32'(ovf));
    check_output({tag, "_underflow_err"}, 32'(underflow_err), 32'(unf));
  endtask

  initial begin
    n_rst                = 1'b0;
    clear                = 1'b0;
    flush                = 1'b0;
    store_tx_data        = 1'b0;
    tx_size              = 2'd0;
    tx_data              = 32'h0;
    get_rx_data          = 1'b0;
    rx_size              = 2'd0;
    store_rx_packet_data = 1'b0;
    rx_packet_data       = 8'h0;
    get_tx_packet_data   = 1'b0;

    // Power-on reset state.
    repeat (2) @(posedge tb_clk);
    #1;
    check_status("por", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("por_rx_data", rx_data, 32'h0);
    check_output("por_tx_packet_data", 32'(tx_packet_data), 32'h0);
    @(negedge tb_clk);
    n_rst = 1'b1;

    // Put the FIFO in a dirty state, then reset it mid-cycle.
    bus_push(2'd0, 32'hFFFF_FF77);
    usb_pop(8'h77);
    usb_pop(8'h77);
    check_status("t1_under", 0, 1'b0, 1'b1, 1'b0, 1'b1);
    bus_push(2'd1, 32'h0000_1234);
    bus_pop(2'd0, 32'h0000_0034);
    check_status("t1_pre", 1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge tb_clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_status("t1_rst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("t1_rst_rx_data", rx_data, 32'h0);
    check_output("t1_rst_tx_packet_data", 32'(tx_packet_data), 32'h0);
    @(negedge tb_clk);
    n_rst = 1'b1;

    // Word bus push drained byte by byte on the USB side.
    bus_push(2'd2, 32'hDDCC_BBAA);
    check_status("t2_push", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    usb_pop(8'hAA);
    usb_pop(8'hBB);
    usb_pop(8'hCC);
    usb_pop(8'hDD);
    check_status("t2_drain", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Fill to DEPTH, overflow once, drain through 1-byte bus pops.
    for (int i = 0; i < 64; i++) usb_push(8'(i));
    check_status("t3_full", 64, 1'b1, 1'b0, 1'b0, 1'b0);
    usb_push(8'hFF);
    check_status("t3_ovf", 64, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) bus_pop(2'd0, 32'(i));
    check_status("t3_drain", 0, 1'b0, 1'b1, 1'b1, 1'b0);
    clear = 1'b1;
    apply_stimulus();
    check_status("t3_clear", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Walk the pointers to 62 so the next word access wraps 62,63,0,1.
    for (int k = 0; k < 62; k++) begin
      usb_push(8'(k));
      usb_pop(8'(k));
    end
    bus_push(2'd2, 32'h4433_2211);
    check_status("t4_wrap_push", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_pop(2'd2, 32'h4433_2211);
    check_status("t4_wrap_pop", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus_push(2'd1, 32'hFFFF_A55A);
    check_status("t4_half", 2, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_pop(2'd1, 32'h0000_A55A);
    bus_push(2'd3, 32'h8765_4321);
    check_status("t4_rsvd", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    bus_pop(2'd3, 32'h8765_4321);

    // Empty FIFO: bus push accepted while the USB pop underflows;
    // tx_packet_data keeps the last byte popped (0x3D from the walk).
    store_tx_data      = 1'b1;
    tx_size            = 2'd0;
    tx_data            = 32'h0000_005A;
    get_tx_packet_data = 1'b1;
    expect_pop(1'b0, 32'h0000_003D);
    apply_stimulus();
    check_status("t5", 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reach occ=10 with overflow from a lost bus push, then flush and clear.
    for (int i = 0; i < 8; i++) usb_push(8'(8'h60 + i));
    store_rx_packet_data = 1'b1;
    rx_packet_data       = 8'h70;
    store_tx_data        = 1'b1;
    tx_size              = 2'd0;
    tx_data              = 32'h0000_00EE;
    apply_stimulus();
    check_status("t6_lost", 10, 1'b0, 1'b0, 1'b1, 1'b1);
    store_tx_data      = 1'b1;
    tx_size            = 2'd1;
    tx_data            = 32'h0000_CAFE;
    get_tx_packet_data = 1'b1;
    expect_pop(1'b0, 32'h0000_005A);
    apply_stimulus();
    check_status("t6_pushpop", 11, 1'b0, 1'b0, 1'b1, 1'b1);
    flush                = 1'b1;
    store_rx_packet_data = 1'b1;
    rx_packet_data       = 8'h42;
    apply_stimulus();
    check_status("t6_flush", 0, 1'b0, 1'b1, 1'b1, 1'b1);
    clear = 1'b1;
    apply_stimulus();
    check_status("t6_clear", 0, 1'b0, 1'b1, 1'b0, 1'b0);
    usb_push(8'h99);
    bus_pop(2'd0, 32'h0000_0099);
    check_status("t6_after", 0, 1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge tb_clk);
    #1;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
